// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache between the CPU
// fetch port and a block-organised instruction memory with busywait handshake.
// Hits are served combinationally; a miss stalls the CPU while the whole block
// is fetched (IDLE -> MEM_READ -> UPDATE -> IDLE).
// Optional hit/miss performance counters are enabled with the macro
// ICACHE_PERF_CNT_EN; without it HIT_COUNT/MISS_COUNT are tied to zero.
module instr_cache #(
  parameter int ADDR_W          = 10,
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 8
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [31:0]                       PC,
  output logic [WORD_W-1:0]                 INSTRUCTION,
  output logic                              CPU_BUSYWAIT,
  output logic                              IM_READ,
  output logic [ADDR_W-3-$clog2(WORDS_PER_BLOCK):0] IM_ADDRESS,
  input  logic [WORD_W*WORDS_PER_BLOCK-1:0] IM_READDATA,
  input  logic                              IM_BUSYWAIT,
  output logic [31:0]                       HIT_COUNT,
  output logic [31:0]                       MISS_COUNT
);

  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_WS  = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int BADDR_W = ADDR_W - 2 - OFF_W;
  localparam int TAG_W   = BADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_READ = 2'd1, UPDATE = 2'd2} state_t;

  state_t                                state;
  logic                                  im_read;
  logic [NUM_SETS-1:0]                   valid;
  logic [TAG_W-1:0]                      tags [NUM_SETS];
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] data [NUM_SETS];

  logic [ADDR_W-3:0] word_addr;
  logic [OFF_WS-1:0] offset;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              unused_pc;

  // Bits of PC outside the lookup window and the byte offset do not matter.
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};
  assign word_addr = PC[ADDR_W-1:2];

  // Split the word address into offset/index/tag (power-of-two sizes make these pure bit slices).
  always_comb begin
    offset     = OFF_WS'(word_addr % WORDS_PER_BLOCK);
    index      = IDX_W'((word_addr / WORDS_PER_BLOCK) % NUM_SETS);
    tag        = TAG_W'(word_addr / (WORDS_PER_BLOCK * NUM_SETS));
    IM_ADDRESS = BADDR_W'(word_addr / WORDS_PER_BLOCK);
  end

  // Lookup, read mux and CPU stall; the stall falls combinationally once the line hits in IDLE.
  always_comb begin
    hit          = valid[index] && (tags[index] == tag);
    INSTRUCTION  = data[index][offset];
    CPU_BUSYWAIT = (state != IDLE) || !hit;
  end

  assign IM_READ = im_read;

  // Miss-handling FSM; reset clears valid bits and drops the memory request immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      im_read <= 1'b0;
      valid   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state   <= MEM_READ;
            im_read <= 1'b1;
          end
        end
        MEM_READ: begin
          if (!IM_BUSYWAIT) begin
            state   <= UPDATE;
            im_read <= 1'b0;
          end
        end
        UPDATE: begin
          valid[index] <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state   <= IDLE;
          im_read <= 1'b0;
        end
      endcase
    end
  end

  // Line fill of tag and data; these arrays are intentionally not reset (valid bits gate them).
  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      data[index] <= IM_READDATA;
      tags[index] <= tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Count IDLE hit cycles and IDLE->MEM_READ transitions, wrapping modulo 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (state == IDLE && hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (state == IDLE && !hit) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;
`else
  assign HIT_COUNT  = 32'd0;
  assign MISS_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus pushes expected fetch results
// computed from a resident-block model; a negedge monitor pops and compares
// whenever the cache releases the CPU. A second instance covers a
// non-default parameter set.
module tb_instr_cache;

  localparam int LAT = 5;

`ifdef ICACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         CPU_BUSYWAIT;
  logic         IM_READ;
  logic [5:0]   IM_ADDRESS;
  logic [127:0] IM_READDATA;
  logic         IM_BUSYWAIT;
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;

  logic [31:0]  pc2;
  logic [31:0]  instruction2;
  logic         cpu_busywait2;
  logic         im_read2;
  logic [6:0]   im_address2;
  logic [255:0] im_readdata2;
  logic         im_busywait2;
  logic [31:0]  hit_count2;
  logic [31:0]  miss_count2;

  instr_cache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .CPU_BUSYWAIT(CPU_BUSYWAIT), .IM_READ(IM_READ), .IM_ADDRESS(IM_ADDRESS),
    .IM_READDATA(IM_READDATA), .IM_BUSYWAIT(IM_BUSYWAIT),
    .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  instr_cache #(.ADDR_W(12), .WORD_W(32), .WORDS_PER_BLOCK(8), .NUM_SETS(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .PC(pc2), .INSTRUCTION(instruction2),
    .CPU_BUSYWAIT(cpu_busywait2), .IM_READ(im_read2), .IM_ADDRESS(im_address2),
    .IM_READDATA(im_readdata2), .IM_BUSYWAIT(im_busywait2),
    .HIT_COUNT(hit_count2), .MISS_COUNT(miss_count2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction memory model ----------------
  logic [31:0] imem [256];
  logic [31:0] blk2_words [8];
  bit          mem_active = 1'b0;
  int          mem_cnt = 0;
  int          mem_addr = 0;

  // Request accepted when IM_READ is seen; response falls LAT cycles later even if aborted.
  always @(negedge CLK) begin
    if (mem_active) begin
      mem_cnt++;
      if (mem_cnt >= LAT) begin
        for (int w = 0; w < 4; w++) IM_READDATA[w*32 +: 32] = imem[mem_addr*4 + w];
        IM_BUSYWAIT = 1'b0;
        mem_active  = 1'b0;
      end
    end else if (IM_READ) begin
      mem_active  = 1'b1;
      mem_cnt     = 1;
      mem_addr    = int'(IM_ADDRESS);
      IM_BUSYWAIT = 1'b1;
    end else begin
      IM_BUSYWAIT = 1'b1;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    bit          miss;
    int          blk;
  } exp_t;

  exp_t sb_q[$];
  int   resident [8];
  int   done_cnt = 0;
  int   busy_cyc = 0;
  bit   rd_seen  = 1'b0;

  task automatic model_clear();
    for (int s = 0; s < 8; s++) resident[s] = -1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    exp_t e;
    int   word;
    int   target;
    word    = int'(pc[9:2]);
    e.blk   = word / 4;
    e.instr = imem[word];
    e.miss  = (resident[e.blk % 8] != e.blk);
    resident[e.blk % 8] = e.blk;
    PC = pc;
    sb_q.push_back(e);
    target = done_cnt + 1;
    for (int k = 0; k < 100 && done_cnt < target; k++) @(posedge CLK);
    if (done_cnt < target) begin
      fails++;
      $display("FAIL fetch_timeout: pc %0h still stalled after 100 cycles", pc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    #1;
  endtask

  // Monitor: checks memory requests and pops an expectation when the CPU is released.
  always @(negedge CLK) begin
    exp_t e;
    if (IM_READ) chk("read_implies_busy", CPU_BUSYWAIT, 1);
    if (!RESET && sb_q.size() > 0) begin
      if (IM_READ) begin
        rd_seen = 1'b1;
        chk("im_address", IM_ADDRESS, sb_q[0].blk);
      end
      if (CPU_BUSYWAIT) begin
        busy_cyc++;
      end else begin
        e = sb_q.pop_front();
        chk("instruction", INSTRUCTION, e.instr);
        chk("miss_seen", busy_cyc != 0, e.miss);
        chk("im_read_seen", rd_seen, e.miss);
        if (e.miss) chk("miss_penalty", busy_cyc, LAT + 2);
        busy_cyc = 0;
        rd_seen  = 1'b0;
        done_cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    RESET        = 1'b1;
    PC           = 32'd0;
    IM_BUSYWAIT  = 1'b1;
    IM_READDATA  = '0;
    pc2          = 32'h0000_03E0;
    im_busywait2 = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h1111_1111;
    imem[1] = 32'h2222_2222;
    imem[2] = 32'h3333_3333;
    imem[3] = 32'h4444_4444;
    for (int w = 0; w < 8; w++) begin
      blk2_words[w] = $urandom;
      im_readdata2[w*32 +: 32] = blk2_words[w];
    end
    model_clear();

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_im_read", IM_READ, 0);
    chk("reset_busywait", CPU_BUSYWAIT, 1);
    chk("reset_busywait2", cpu_busywait2, 1);
    chk("reset_hit_count", HIT_COUNT, 0);
    chk("reset_miss_count", MISS_COUNT, 0);

    // Cold miss followed by spatial hits in the same block.
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);
    fetch(32'd12);
    chk("miss_count", MISS_COUNT, PERF ? 1 : 0);
    chk("hit_count", HIT_COUNT, PERF ? 4 : 0);

    // Conflict eviction on set 0.
    fetch(32'd0);
    fetch(32'd128);
    fetch(32'd0);

    // Reset two cycles into a fill of block 8; the late response must be ignored.
    PC = 32'd128;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("midfill_reset_im_read", IM_READ, 0);
    chk("midfill_reset_busy", CPU_BUSYWAIT, 1);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_clear();
    fetch(32'd0);
    fetch(32'd12);

    // Randomized fetches; upper PC bits are noise the cache must ignore.
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      if (n % 3 == 0) fetch({r[31:10], 6'(r[5:0] & 6'h0F), 4'b0000} | {28'd0, 2'(r[7:6]), 2'b00});
      else fetch({r[31:10], 8'($urandom_range(0, 255)), 2'(r[1:0])});
    end

    // Non-default geometry: 7-bit block address, fill of block 0x1F.
    chk("p2_im_address", im_address2, 7'h1F);
    chk("p2_busy", cpu_busywait2, 0);
    chk("p2_word0", instruction2, blk2_words[0]);
    pc2 = 32'h0000_03E0 + 32'd28;
    #1;
    chk("p2_busy_w7", cpu_busywait2, 0);
    chk("p2_word7", instruction2, blk2_words[7]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
